ex_hazard_ctrl: RTL and testbench
=================================

Name: ex_hazard_ctrl

Overview:
- Pipeline hazard and control-flow sequencer for the EX stage.
- Detects load-use hazards between ID and EX and inserts one bubble.
- Holds fetch/decode while a ret waits for the stack-pointer PC (ret_wb).
- Flushes IF/ID and ID/EX for a fixed number of cycles after a taken branch, call or ret resolves in EX.

Parameters:
FLUSH_CYCLES, 2, cycles flush_if_id/flush_id_ex stay high after a taken PC update (1..7)
CNT_W, 16, width of the stall-cycle statistics counter

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous active-low reset
id_rs1  input  4  ID-stage source register 1
id_rs2  input  4  ID-stage source register 2
id_rs1_used  input  1  ID instruction reads id_rs1
id_rs2_used  input  1  ID instruction reads id_rs2
id_ret  input  1  ID-stage instruction is ret
ex_mem_to_reg  input  1  EX-stage instruction is a load
ex_reg_rd  input  4  EX-stage destination register
ret_wb  input  1  stack-pointer PC ready for ret
pc_update_done  input  1  EX PC update complete this cycle
pc_src  input  1  PC update taken (1) / fall-through (0)
stall_if  output  1  hold PC and IF/ID register
stall_id  output  1  hold ID/EX inputs
bubble_ex  output  1  load NOP controls into ID/EX
flush_if_id  output  1  clear IF/ID register
flush_id_ex  output  1  clear ID/EX register
ret_pending  output  1  ret waiting for ret_wb
stall_count  output  CNT_W  stall-cycle count (HAZARD_STATS_EN only)

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low on rst_n.
- Reset: state=IDLE, flush counter=0, stall_count=0, all outputs 0.
- States: IDLE, FLUSH, RET_WAIT.
- Load-use detection (lu):
  - lu = ex_mem_to_reg & ex_reg_rd!=0 & ((id_rs1_used & id_rs1==ex_reg_rd) | (id_rs2_used & id_rs2==ex_reg_rd)).
  - R0 never causes a hazard.
- Event priority when evaluated in the same cycle: taken update > ret > load-use.
- IDLE:
  - pc_update_done & pc_src: next state FLUSH, counter loads FLUSH_CYCLES-1.
  - Else id_ret: next state RET_WAIT.
  - Else lu: stall_if=stall_id=bubble_ex=1 combinationally in the same cycle (Mealy); stay in IDLE. Exactly one bubble per load, because the load leaves EX next cycle.
  - pc_update_done & !pc_src: no action.
- FLUSH:
  - flush_if_id=flush_id_ex=1 (Moore) for exactly FLUSH_CYCLES consecutive cycles, starting the cycle after the taken update.
  - Counter decrements each cycle; at 0 the next state is IDLE.
  - lu and id_ret are ignored, because the instructions are being squashed.
  - A new taken update during FLUSH reloads the counter (restarts the window).
- RET_WAIT:
  - ret_pending=stall_if=1, and bubble_ex=1 every cycle.
  - stall_id=1 keeps ret in ID until resolved.
  - On ret_wb=1: next state FLUSH with counter=FLUSH_CYCLES-1. The wrong-path fetch behind ret is flushed.
  - A taken update in RET_WAIT also goes to FLUSH (priority rule); ret_pending drops.
  - There is no timeout; the block waits indefinitely.
- Outputs other than the lu Mealy terms are decoded from registered state only; no other combinational input-to-output paths.
- Reset mid-operation (any state, any counter value): returns to IDLE next edge with outputs deasserted; a pending ret is dropped.
- Widths: ex_reg_rd, id_rs1 and id_rs2 are compared as 4-bit equality; no X-propagation tolerance required.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- Defined:
  - stall_count increments by 1 on every cycle where stall_if=1.
  - Saturates at all-ones (no wrap).
  - Cleared only by reset.
- Undefined:
  - stall_count tied to 0; no counter flops synthesised.
  - All other behaviour is identical.

Test Plan:
- Load-use: ex_mem_to_reg=1, ex_reg_rd=5, id_rs2=5, id_rs2_used=1 -> stall_if=stall_id=bubble_ex=1 same cycle only. Same stimulus with ex_reg_rd=0 -> no stall.
- Taken branch: pc_update_done=1, pc_src=1 for one cycle, FLUSH_CYCLES=2 -> flush_if_id=flush_id_ex=1 on exactly the next 2 cycles, then 0. Same with pc_src=0 -> no flush.
- Ret: id_ret=1, ret_wb asserted 4 cycles later -> ret_pending/stall_if/bubble_ex high for 4 cycles, then 2 flush cycles, then IDLE.
- Simultaneous events: pc_update_done=pc_src=1 with id_ret=1 and an lu hazard in IDLE -> FLUSH taken, no stall. Second taken update during FLUSH -> window restarts for 2 full cycles.
- Reset mid-operation: rst_n=0 for one edge during RET_WAIT -> all outputs 0 next cycle, state IDLE, stall_count=0.
- Stats (HAZARD_STATS_EN, CNT_W=4): hold RET_WAIT 20 cycles -> stall_count saturates at 15. Without the macro -> stall_count=0 throughout.

Source files
------------

// File: rtl/ex_hazard_ctrl.sv
// ex_hazard_ctrl: EX-stage hazard and control-flow sequencer.
// Inserts one bubble on a load-use hazard, stalls fetch/decode while a ret
// waits for its stack-pointer PC, and flushes IF/ID and ID/EX for
// FLUSH_CYCLES cycles after any taken PC update (branch, call or ret).
// Optional feature macro: HAZARD_STATS_EN enables the saturating
// stall-cycle counter on stall_count; without it stall_count is tied to 0.
module ex_hazard_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       id_rs1,
    input  logic [3:0]       id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic             id_ret,
    input  logic             ex_mem_to_reg,
    input  logic [3:0]       ex_reg_rd,
    input  logic             ret_wb,
    input  logic             pc_update_done,
    input  logic             pc_src,
    output logic             stall_if,
    output logic             stall_id,
    output logic             bubble_ex,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             ret_pending,
    output logic [CNT_W-1:0] stall_count
);

    typedef enum logic [1:0] {
        IDLE,
        FLUSH,
        RET_WAIT
    } state_t;

    // The flush counter holds the number of flush cycles still to follow the
    // current one, so it is loaded with FLUSH_CYCLES-1.
    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

    state_t     state, state_next;
    logic [2:0] flush_cnt, flush_cnt_next;
    logic       taken;
    logic       lu;

    assign taken = pc_update_done & pc_src;

    // R0 is hardwired to zero, so a load targeting it can never create a hazard.
    assign lu = ex_mem_to_reg && (ex_reg_rd != 4'd0) &&
                ((id_rs1_used && (id_rs1 == ex_reg_rd)) ||
                 (id_rs2_used && (id_rs2 == ex_reg_rd)));

    // State and flush counter registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            flush_cnt <= 3'd0;
        end else begin
            state     <= state_next;
            flush_cnt <= flush_cnt_next;
        end
    end

    // Next-state and output decode; taken update beats ret, ret beats load-use.
    always_comb begin
        state_next     = state;
        flush_cnt_next = flush_cnt;
        stall_if       = 1'b0;
        stall_id       = 1'b0;
        bubble_ex      = 1'b0;
        flush_if_id    = 1'b0;
        flush_id_ex    = 1'b0;
        ret_pending    = 1'b0;
        case (state)
            IDLE: begin
                if (taken) begin
                    state_next     = FLUSH;
                    flush_cnt_next = FLUSH_LOAD;
                end else if (id_ret) begin
                    state_next = RET_WAIT;
                end else if (lu) begin
                    stall_if  = 1'b1;
                    stall_id  = 1'b1;
                    bubble_ex = 1'b1;
                end
            end
            FLUSH: begin
                flush_if_id = 1'b1;
                flush_id_ex = 1'b1;
                if (taken) begin
                    flush_cnt_next = FLUSH_LOAD;
                end else if (flush_cnt == 3'd0) begin
                    state_next = IDLE;
                end else begin
                    flush_cnt_next = flush_cnt - 3'd1;
                end
            end
            RET_WAIT: begin
                ret_pending = 1'b1;
                stall_if    = 1'b1;
                stall_id    = 1'b1;
                bubble_ex   = 1'b1;
                if (taken || ret_wb) begin
                    state_next     = FLUSH;
                    flush_cnt_next = FLUSH_LOAD;
                end
            end
            default: begin
                state_next     = IDLE;
                flush_cnt_next = 3'd0;
            end
        endcase
    end

`ifdef HAZARD_STATS_EN
    logic [CNT_W-1:0] stall_cnt_q;

    // Count stalled cycles, holding at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (stall_if && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    assign stall_count = stall_cnt_q;
`else
    assign stall_count = '0;
`endif

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// tb_ex_hazard_ctrl: directed plus randomized stimulus for ex_hazard_ctrl,
// checked every cycle against a behavioural model built from a remaining
// flush-cycle count and a ret-waiting flag.
module tb_ex_hazard_ctrl;

    localparam int FLUSH_CYCLES = 2;
    localparam int CNT_W        = 4;
    localparam int CNT_MAX      = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [3:0]       id_rs1, id_rs2, ex_reg_rd;
    logic             id_rs1_used, id_rs2_used, id_ret, ex_mem_to_reg;
    logic             ret_wb, pc_update_done, pc_src;
    logic             stall_if, stall_id, bubble_ex;
    logic             flush_if_id, flush_id_ex, ret_pending;
    logic [CNT_W-1:0] stall_count;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int flush_left  = 0;
    bit ret_waiting = 1'b0;
    int exp_count   = 0;

    always #5 clk = ~clk;

    ex_hazard_ctrl #(
        .FLUSH_CYCLES(FLUSH_CYCLES),
        .CNT_W       (CNT_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .id_rs1_used   (id_rs1_used),
        .id_rs2_used   (id_rs2_used),
        .id_ret        (id_ret),
        .ex_mem_to_reg (ex_mem_to_reg),
        .ex_reg_rd     (ex_reg_rd),
        .ret_wb        (ret_wb),
        .pc_update_done(pc_update_done),
        .pc_src        (pc_src),
        .stall_if      (stall_if),
        .stall_id      (stall_id),
        .bubble_ex     (bubble_ex),
        .flush_if_id   (flush_if_id),
        .flush_id_ex   (flush_id_ex),
        .ret_pending   (ret_pending),
        .stall_count   (stall_count)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs, check outputs mid-cycle, advance the model.
    task automatic applyStimulus(input bit r, input logic [3:0] rs1, input logic [3:0] rs2,
                                 input bit u1, input bit u2, input bit ret, input bit mtr,
                                 input logic [3:0] rd, input bit wb, input bit pud, input bit src);
        bit taken, lu, e_flush, e_ret, e_lu, e_stall;
        rst_n          = r;
        id_rs1         = rs1;
        id_rs2         = rs2;
        id_rs1_used    = u1;
        id_rs2_used    = u2;
        id_ret         = ret;
        ex_mem_to_reg  = mtr;
        ex_reg_rd      = rd;
        ret_wb         = wb;
        pc_update_done = pud;
        pc_src         = src;
        @(negedge clk);

        taken   = pud && src;
        lu      = mtr && (rd != 0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
        e_flush = (flush_left > 0);
        e_ret   = !e_flush && ret_waiting;
        e_lu    = !e_flush && !ret_waiting && lu && !taken && !ret;
        e_stall = e_ret || e_lu;

        checkOutput("stall_if",    32'(stall_if),    32'(e_stall));
        checkOutput("stall_id",    32'(stall_id),    32'(e_stall));
        checkOutput("bubble_ex",   32'(bubble_ex),   32'(e_stall));
        checkOutput("flush_if_id", 32'(flush_if_id), 32'(e_flush));
        checkOutput("flush_id_ex", 32'(flush_id_ex), 32'(e_flush));
        checkOutput("ret_pending", 32'(ret_pending), 32'(e_ret));
`ifdef HAZARD_STATS_EN
        checkOutput("stall_count", 32'(stall_count), 32'(exp_count));
`else
        checkOutput("stall_count", 32'(stall_count), 32'd0);
`endif

        if (!r) begin
            flush_left  = 0;
            ret_waiting = 1'b0;
            exp_count   = 0;
        end else begin
            if (e_stall && exp_count < CNT_MAX) exp_count++;
            if (taken) begin
                flush_left  = FLUSH_CYCLES;
                ret_waiting = 1'b0;
            end else if (ret_waiting && wb) begin
                flush_left  = FLUSH_CYCLES;
                ret_waiting = 1'b0;
            end else if (flush_left > 0) begin
                flush_left--;
            end else if (!ret_waiting && ret) begin
                ret_waiting = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++)
            applyStimulus(1, 4'd0, 4'd0, 0, 0, 0, 0, 4'd0, 0, 0, 0);
    endtask

    initial begin
        // First reset edge brings the DUT out of its unknown power-up state.
        rst_n = 1'b0;
        {id_rs1, id_rs2, ex_reg_rd} = '0;
        {id_rs1_used, id_rs2_used, id_ret, ex_mem_to_reg} = '0;
        {ret_wb, pc_update_done, pc_src} = '0;
        @(posedge clk);
        #1;
        applyStimulus(0, 4'd0, 4'd0, 0, 0, 0, 0, 4'd0, 0, 0, 0);

        // Load-use via rs2, then R0 destination, rs1 path, and unused operand
        applyStimulus(1, 4'd1, 4'd5, 0, 1, 0, 1, 4'd5, 0, 0, 0);
        idleCycles(1);
        applyStimulus(1, 4'd0, 4'd0, 1, 1, 0, 1, 4'd0, 0, 0, 0);
        applyStimulus(1, 4'd3, 4'd7, 1, 0, 0, 1, 4'd3, 0, 0, 0);
        applyStimulus(1, 4'd3, 4'd3, 0, 0, 0, 1, 4'd3, 0, 0, 0);
        applyStimulus(1, 4'd6, 4'd6, 1, 1, 0, 0, 4'd6, 0, 0, 0);

        // Taken branch then fall-through
        applyStimulus(1, 4'd0, 4'd0, 0, 0, 0, 0, 4'd0, 0, 1, 1);
        idleCycles(3);
        applyStimulus(1, 4'd0, 4'd0, 0, 0, 0, 0, 4'd0, 0, 1, 0);
        idleCycles(2);

        // Ret waiting four cycles for ret_wb
        applyStimulus(1, 4'd0, 4'd0, 0, 0, 1, 0, 4'd0, 0, 0, 0);
        idleCycles(3);
        applyStimulus(1, 4'd0, 4'd0, 0, 0, 0, 0, 4'd0, 1, 0, 0);
        idleCycles(3);

        // Simultaneous taken + ret + load-use, then re-taken during flush
        applyStimulus(1, 4'd2, 4'd0, 1, 0, 1, 1, 4'd2, 0, 1, 1);
        applyStimulus(1, 4'd0, 4'd0, 0, 0, 0, 0, 4'd0, 0, 1, 1);
        applyStimulus(1, 4'd4, 4'd0, 1, 0, 1, 1, 4'd4, 0, 0, 0);
        idleCycles(3);

        // Reset in RET_WAIT
        applyStimulus(1, 4'd0, 4'd0, 0, 0, 1, 0, 4'd0, 0, 0, 0);
        idleCycles(2);
        applyStimulus(0, 4'd0, 4'd0, 0, 0, 0, 0, 4'd0, 0, 0, 0);
        idleCycles(2);

        // Long RET_WAIT to drive the stall counter into saturation
        applyStimulus(1, 4'd0, 4'd0, 0, 0, 1, 0, 4'd0, 0, 0, 0);
        idleCycles(20);
        applyStimulus(1, 4'd0, 4'd0, 0, 0, 0, 0, 4'd0, 1, 0, 0);
        idleCycles(3);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            applyStimulus($urandom_range(49) != 0,
                          4'($urandom_range(7)), 4'($urandom_range(7)),
                          1'($urandom), 1'($urandom),
                          $urandom_range(9) == 0, 1'($urandom),
                          4'($urandom_range(7)),
                          $urandom_range(3) == 0,
                          $urandom_range(7) == 0, 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
